// File: rtl/seven_seg_pkg.sv
// Shared types and glyph table for the seven-segment display monitor.
// Combinational constants only: no latency, no flow control.
package seven_seg_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } state_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam int NUM_DIGITS = 8;

  // Active-high segment pattern for each hex nibble, indexed by nibble value.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] bto7s(input logic [3:0] nibble);
    return GLYPH[nibble];
  endfunction

endpackage

// File: rtl/s7tob.sv
// Seven-segment pattern back to hex nibble; inverse of bto7s.
// Purely combinational, no backpressure; hit=0 for any pattern outside the table.
module s7tob
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_h,
  output logic       hit,
  output logic [3:0] nibble
);

  always_comb begin
    hit    = 1'b0;
    nibble = 4'h0;
    for (int k = 0; k < 16; k++) begin
      if (seg_h == GLYPH[k]) begin
        hit    = 1'b1;
        nibble = 4'(k);
      end
    end
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Rebuilds the 32-bit value shown on a multiplexed 8-digit display; one sample per settled dwell.
// Last digit pin edge to valid_out is 2 + SETTLE_CYCLES + 1 cycles; passive monitor, no backpressure.
module seven_segment_decoder
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [6:0]                cat_in,
  input  logic [NUM_DIGITS-1:0]     an_in,
  output logic [4*NUM_DIGITS-1:0]   val_out,
  output logic                      valid_out,
  output logic                      digit_err_out,
  output logic                      glyph_err_out,
  output logic                      timeout_out
);

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST  = SCW'(SETTLE_CYCLES - 1);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

  logic [NUM_DIGITS-1:0]   an_s1, an_s2;
  logic [6:0]              cat_s1, cat_s2;
  logic [NUM_DIGITS-1:0]   an_h;
  logic [SEG_G:SEG_A]      seg_h;
  logic [NUM_DIGITS+6:0]   prev_q;
  logic                    changed;

  state_t                  state_q, state_d;
  logic [SCW-1:0]          settle_cnt;
  logic                    eval;

  logic [TCW-1:0]          tmo_cnt;
  logic [NUM_DIGITS-1:0]   seen_q;
  logic [4*NUM_DIGITS-1:0] shadow_q;

  logic                    single, multi;
  logic [2:0]              dig_idx;
  logic                    glyph_hit;
  logic [3:0]              glyph_nib;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   seen_set;
  logic [4*NUM_DIGITS-1:0] shadow_mrg;

  // Resetting to all-ones makes the bus look idle until real pin values propagate.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      an_s1  <= '1;
      an_s2  <= '1;
      cat_s1 <= '1;
      cat_s2 <= '1;
      prev_q <= '0;
    end else begin
      an_s1  <= an_in;
      an_s2  <= an_s1;
      cat_s1 <= cat_in;
      cat_s2 <= cat_s1;
      prev_q <= {an_h, seg_h};
    end
  end

  assign an_h    = ~an_s2;
  assign seg_h   = ~cat_s2;
  assign changed = ({an_h, seg_h} != prev_q);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state_q <= SETTLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (changed)
      state_d = SETTLE;
    else if (state_q == SETTLE && settle_cnt == SETTLE_LAST)
      state_d = HOLD;
  end

  always_comb begin
    eval = !changed && (state_q == SETTLE) && (settle_cnt == SETTLE_LAST);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in)
      settle_cnt <= '0;
    else if (changed)
      settle_cnt <= '0;
    else if (state_q == SETTLE && !eval)
      settle_cnt <= settle_cnt + 1'b1;
  end

  assign single = (an_h != '0) && ((an_h & (an_h - 8'd1)) == '0);
  assign multi  = (an_h != '0) && !single;

  always_comb begin
    dig_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_h[i]) dig_idx = 3'(i);
    end
  end

  s7tob u_s7tob (
    .seg_h  (seg_h),
    .hit    (glyph_hit),
    .nibble (glyph_nib)
  );

  assign capture  = eval && single && glyph_hit;
  assign seen_set = seen_q | (NUM_DIGITS'(1) << dig_idx);

  always_comb begin
    shadow_mrg = shadow_q;
    shadow_mrg[{dig_idx, 2'b00} +: 4] = glyph_nib;
  end

  // Only a glyph hit can complete a scan, so valid and the error pulses never coincide.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      val_out       <= '0;
      valid_out     <= 1'b0;
      digit_err_out <= 1'b0;
      glyph_err_out <= 1'b0;
      timeout_out   <= 1'b0;
      seen_q        <= '0;
      shadow_q      <= '0;
      tmo_cnt       <= '0;
    end else begin
      valid_out     <= 1'b0;
      timeout_out   <= 1'b0;
      digit_err_out <= eval && multi;
      glyph_err_out <= eval && single && !glyph_hit;
      if (capture) begin
        tmo_cnt  <= '0;
        shadow_q <= shadow_mrg;
        if (seen_set == '1) begin
          val_out   <= shadow_mrg;
          valid_out <= 1'b1;
          seen_q    <= '0;
        end else begin
          seen_q    <= seen_set;
        end
      end else if (seen_q != '0) begin
        if (tmo_cnt == TIMEOUT_LAST) begin
          seen_q      <= '0;
          timeout_out <= 1'b1;
          tmo_cnt     <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: vector table, directed scans and randomized dwells
// checked against a dwell-level model of the display bus.
module tb_seven_segment_decoder;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 500;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [6:0]  cat_in;
  logic [7:0]  an_in;
  logic [31:0] val_out;
  logic        valid_out, digit_err_out, glyph_err_out, timeout_out;

  always #5 clk_in = ~clk_in;

  seven_segment_decoder #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .cat_in        (cat_in),
    .an_in         (an_in),
    .val_out       (val_out),
    .valid_out     (valid_out),
    .digit_err_out (digit_err_out),
    .glyph_err_out (glyph_err_out),
    .timeout_out   (timeout_out)
  );

  int checks = 0, failures = 0;
  int n_valid = 0, n_derr = 0, n_gerr = 0, n_tmo = 0;
  int e_valid = 0, e_derr = 0, e_gerr = 0, e_tmo = 0;

  logic [31:0] m_val;
  logic [7:0]  m_seen;
  logic [3:0]  m_nib [8];
  logic [14:0] last_pat;
  logic [6:0]  seg_of [16];

  typedef struct {
    logic [7:0]  an_h;
    logic [6:0]  seg_h;
    int          d_derr;
    int          d_gerr;
    int          d_valid;
    logic [31:0] val;
  } vec_t;
  vec_t tbl [12];

  always @(posedge clk_in) begin
    #1;
    if (valid_out === 1'b1)     n_valid++;
    if (digit_err_out === 1'b1) n_derr++;
    if (glyph_err_out === 1'b1) n_gerr++;
    if (timeout_out === 1'b1)   n_tmo++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid_cnt"}, n_valid, e_valid);
    chk({tag, "_derr_cnt"},  n_derr,  e_derr);
    chk({tag, "_gerr_cnt"},  n_gerr,  e_gerr);
    chk({tag, "_tmo_cnt"},   n_tmo,   e_tmo);
    chk({tag, "_val"},       val_out, m_val);
  endtask

  function automatic int glyph_index(input logic [6:0] seg);
    int r = -1;
    for (int k = 0; k < 16; k++) if (seg_of[k] == seg) r = k;
    return r;
  endfunction

  task automatic model_eval(input logic [7:0] an_h, input logic [6:0] seg_h);
    int cnt = 0;
    int idx = 0;
    int nib;
    for (int i = 0; i < 8; i++) if (an_h[i]) begin cnt++; idx = i; end
    if (cnt > 1) e_derr++;
    else if (cnt == 1) begin
      nib = glyph_index(seg_h);
      if (nib < 0) e_gerr++;
      else begin
        m_nib[idx]  = 4'(nib);
        m_seen[idx] = 1'b1;
        if (m_seen == 8'hFF) begin
          e_valid++;
          m_val  = {m_nib[7], m_nib[6], m_nib[5], m_nib[4],
                    m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
          m_seen = 8'h00;
        end
      end
    end
  endtask

  // A dwell long enough to settle is evaluated once, unless it continues the previous pattern.
  task automatic dwell(input logic [7:0] an_h, input logic [6:0] seg_h, input int len);
    an_in  = ~an_h;
    cat_in = ~seg_h;
    if ({an_h, seg_h} != last_pat && len >= SETTLE + 4) model_eval(an_h, seg_h);
    last_pat = {an_h, seg_h};
    repeat (len) @(negedge clk_in);
    check_all("dwell");
  endtask

  task automatic show_digits(input logic [31:0] v, input int first, input int last, input int len);
    for (int d = first; d <= last; d++) dwell(8'(1 << d), seg_of[v[4*d +: 4]], len);
  endtask

  task automatic do_reset();
    an_in    = 8'hFF;
    cat_in   = 7'h7F;
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    m_val    = 32'h0;
    m_seen   = 8'h00;
    for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
    last_pat = 15'h0;
  endtask

  initial begin
    logic [7:0] r_an;
    logic [6:0] r_seg;
    int r, nonhit_run;
    bit hit;
    int b_valid, b_derr, b_gerr;

    seg_of = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    an_in    = 8'hFF;
    cat_in   = 7'h7F;
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    do_reset();
    chk("rst_val",   val_out,       32'h0);
    chk("rst_valid", valid_out,     1'b0);
    chk("rst_derr",  digit_err_out, 1'b0);
    chk("rst_gerr",  glyph_err_out, 1'b0);
    chk("rst_tmo",   timeout_out,   1'b0);

    tbl[0]  = '{8'h01, 7'h3F, 0, 0, 0, 32'h0};
    tbl[1]  = '{8'h02, 7'h06, 0, 0, 0, 32'h0};
    tbl[2]  = '{8'h0C, 7'h06, 1, 0, 0, 32'h0};
    tbl[3]  = '{8'h04, 7'h00, 0, 1, 0, 32'h0};
    tbl[4]  = '{8'h04, 7'h5B, 0, 0, 0, 32'h0};
    tbl[5]  = '{8'h00, 7'h00, 0, 0, 0, 32'h0};
    tbl[6]  = '{8'h08, 7'h4F, 0, 0, 0, 32'h0};
    tbl[7]  = '{8'h10, 7'h66, 0, 0, 0, 32'h0};
    tbl[8]  = '{8'h20, 7'h01, 0, 1, 0, 32'h0};
    tbl[9]  = '{8'h20, 7'h6D, 0, 0, 0, 32'h0};
    tbl[10] = '{8'h40, 7'h7D, 0, 0, 0, 32'h0};
    tbl[11] = '{8'h80, 7'h07, 0, 0, 1, 32'h76543210};
    for (int i = 0; i < 12; i++) begin
      b_valid = n_valid; b_derr = n_derr; b_gerr = n_gerr;
      an_in  = ~tbl[i].an_h;
      cat_in = ~tbl[i].seg_h;
      repeat (60) @(negedge clk_in);
      chk("tbl_derr",  n_derr - b_derr,   tbl[i].d_derr);
      chk("tbl_gerr",  n_gerr - b_gerr,   tbl[i].d_gerr);
      chk("tbl_valid", n_valid - b_valid, tbl[i].d_valid);
      chk("tbl_val",   val_out,           tbl[i].val);
      e_derr  += tbl[i].d_derr;
      e_gerr  += tbl[i].d_gerr;
      e_valid += tbl[i].d_valid;
    end
    do_reset();
    check_all("post_tbl_reset");

    show_digits(32'hDEADBEEF, 0, 7, 100);

    show_digits(32'h12345678, 0, 2, 100);
    dwell(8'h08, seg_of[8], 5);
    show_digits(32'h12345678, 3, 7, 100);

    show_digits(32'hA5A5A5A5, 0, 3, 100);
    dwell(8'h03, 7'h06, 100);
    show_digits(32'hA5A5A5A5, 4, 7, 100);

    show_digits(32'h89ABCDEF, 0, 1, 100);
    dwell(8'h04, 7'h00, 100);
    show_digits(32'h89ABCDEF, 3, 7, 100);
    show_digits(32'h89ABCDEF, 2, 2, 100);

    show_digits(32'hCAFEF00D, 0, 3, 100);
    do_reset();
    check_all("mid_scan_reset");
    show_digits(32'hCAFEF00D, 4, 7, 100);
    show_digits(32'hCAFEF00D, 0, 3, 100);

    show_digits(32'h0BADF00D, 0, 2, 100);
    an_in    = 8'hFF;
    cat_in   = 7'h7F;
    last_pat = 15'h0;
    repeat (410) @(negedge clk_in);
    chk("tmo_early", n_tmo, e_tmo);
    repeat (20) @(negedge clk_in);
    e_tmo++;
    m_seen = 8'h00;
    chk("tmo_pulse", n_tmo, e_tmo);
    repeat (170) @(negedge clk_in);
    check_all("tmo_after");

    nonhit_run = 0;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (nonhit_run >= 4) r = 0;
      if (r <= 6) begin
        r_an  = 8'(1 << $urandom_range(0, 7));
        r_seg = seg_of[$urandom_range(0, 15)];
      end else if (r == 7) begin
        r_an = 8'(1 << $urandom_range(0, 7));
        do r_seg = 7'($urandom); while (glyph_index(r_seg) >= 0);
      end else if (r == 8) begin
        do r_an = 8'($urandom); while ($countones(r_an) < 2);
        r_seg = 7'($urandom);
      end else begin
        r_an  = 8'h00;
        r_seg = 7'($urandom);
      end
      hit = (r <= 6) && ({r_an, r_seg} != last_pat);
      nonhit_run = hit ? 0 : nonhit_run + 1;
      dwell(r_an, r_seg, 40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
